// File: rtl/gate_load_conditioner_pkg.sv
// gate_load_conditioner_pkg: shared FSM state encoding and default parameter values
package gate_load_conditioner_pkg;
  localparam int WIDTH_DEF = 4;
  localparam int SYNC_STAGES_DEF = 2;
  localparam int DEBOUNCE_CYCLES_DEF = 1200;
  typedef enum logic [1:0] {IDLE_LOW, CHECK_HIGH, IDLE_HIGH, CHECK_LOW} state_t;
endpackage

// File: rtl/gate_load_conditioner_if.sv
// gate_load_conditioner_if: pin bundle (I, GATE in; O, LOAD, GATE_LEVEL, BUSY out), slave modport for the conditioner
interface gate_load_conditioner_if import gate_load_conditioner_pkg::*; #(parameter int WIDTH = WIDTH_DEF);
  logic [WIDTH-1:0] I;
  logic [WIDTH-1:0] O;
  logic GATE;
  logic LOAD;
  logic GATE_LEVEL;
  logic BUSY;
  modport master(output I, GATE, input O, LOAD, GATE_LEVEL, BUSY);
  modport slave(input I, GATE, output O, LOAD, GATE_LEVEL, BUSY);
endinterface

// File: rtl/gate_load_conditioner_sync_chain.sv
// sync_chain: W-bit synchroniser of STAGES flops with sync reset (clk, rst, d in, q out)
module sync_chain #(
  parameter int W = 1,
  parameter int STAGES = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  logic [W-1:0] r [STAGES];
  always_ff @(posedge clk) begin
    if (rst) r <= '{default: '0};
    else begin
      r[0] <= d;
      for (int i = 1; i < STAGES; i++) r[i] <= r[i-1];
    end
  end
  assign q = r[STAGES-1];
endmodule

// File: rtl/gate_load_conditioner.sv
// gate_load_conditioner: sync + debounce GATE, emit one-cycle LOAD with captured O (CLK, RESET, bus: I/GATE in, O/LOAD/GATE_LEVEL/BUSY out)
module gate_load_conditioner import gate_load_conditioner_pkg::*; #(
  parameter int WIDTH = WIDTH_DEF,
  parameter int SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input logic CLK,
  input logic RESET,
  gate_load_conditioner_if.slave bus
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);
  if (DEBOUNCE_CYCLES < 1 || SYNC_STAGES < 2) begin : g_bad_params
    $error("gate_load_conditioner: DEBOUNCE_CYCLES must be >=1 and SYNC_STAGES >=2");
  end
  logic gate_s;
  logic [WIDTH-1:0] data_s;
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic load_n;
  sync_chain #(.W(1), .STAGES(SYNC_STAGES)) u_gate_sync (.clk(CLK), .rst(RESET), .d(bus.GATE), .q(gate_s));
  sync_chain #(.W(WIDTH), .STAGES(SYNC_STAGES)) u_data_sync (.clk(CLK), .rst(RESET), .d(bus.I), .q(data_s));
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    unique case (state)
      IDLE_LOW: if (gate_s) begin
        state_n = CHECK_HIGH;
        cnt_n = '0;
      end
      CHECK_HIGH: if (!gate_s) begin
        state_n = IDLE_LOW;
        cnt_n = '0;
      end else if (cnt == LAST) state_n = IDLE_HIGH;
      else cnt_n = cnt + 1'b1;
      IDLE_HIGH: if (!gate_s) begin
        state_n = CHECK_LOW;
        cnt_n = '0;
      end
      CHECK_LOW: if (gate_s) begin
        state_n = IDLE_HIGH;
        cnt_n = '0;
      end else if (cnt == LAST) state_n = IDLE_LOW;
      else cnt_n = cnt + 1'b1;
    endcase
    load_n = state == CHECK_HIGH && state_n == IDLE_HIGH;
  end
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state <= IDLE_LOW;
      cnt <= '0;
      bus.O <= '0;
      bus.LOAD <= 1'b0;
      bus.GATE_LEVEL <= 1'b0;
      bus.BUSY <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      bus.LOAD <= load_n;
      if (load_n) bus.O <= data_s;
      bus.GATE_LEVEL <= state_n == IDLE_HIGH || state_n == CHECK_LOW;
      bus.BUSY <= state_n == CHECK_HIGH || state_n == CHECK_LOW;
    end
  end
endmodule

// File: tb/tb_gate_load_conditioner.sv
// tb_gate_load_conditioner: vector table, directed corner sequences and random stimulus against a run-length debounce model
module tb_gate_load_conditioner;
  localparam int W = 4;
  localparam int SS = 2;
  localparam int DB = 4;
  logic CLK = 1'b0;
  logic RESET = 1'b1;
  int n_chk = 0;
  int n_fail = 0;
  gate_load_conditioner_if #(.WIDTH(W)) bus ();
  gate_load_conditioner #(.WIDTH(W), .SYNC_STAGES(SS), .DEBOUNCE_CYCLES(DB)) dut (.CLK(CLK), .RESET(RESET), .bus(bus));
  always #5 CLK = ~CLK;
  logic [W:0] mq[$];
  logic m_lvl, m_load, m_busy;
  logic [W-1:0] m_o;
  int m_run;
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    n_chk++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, a, e, $time);
    end
  endtask
  task automatic model_reset();
    mq.delete();
    for (int i = 0; i < SS; i++) mq.push_back('0);
    m_lvl = 0;
    m_load = 0;
    m_busy = 0;
    m_o = '0;
    m_run = 0;
  endtask
  task automatic model_step(input logic g, input logic [W-1:0] d);
    logic [W:0] seen;
    seen = mq.pop_front();
    mq.push_back({g, d});
    m_load = 0;
    if (seen[W] != m_lvl) begin
      m_run++;
      if (m_run == DB + 1) begin
        m_lvl = seen[W];
        m_run = 0;
        if (m_lvl) begin
          m_load = 1;
          m_o = seen[W-1:0];
        end
      end
    end else m_run = 0;
    m_busy = m_run > 0;
  endtask
  task automatic tick(input logic r, input logic g, input logic [W-1:0] d);
    RESET = r;
    bus.GATE = g;
    bus.I = d;
    @(posedge CLK);
    if (r) model_reset();
    else model_step(g, d);
    #1;
    chk("model_LOAD", bus.LOAD, m_load);
    chk("model_O", bus.O, m_o);
    chk("model_GATE_LEVEL", bus.GATE_LEVEL, m_lvl);
    chk("model_BUSY", bus.BUSY, m_busy);
  endtask
  typedef struct {
    logic rst;
    logic gate;
    logic [W-1:0] i;
    logic load;
    logic lvl;
    logic busy;
    logic [W-1:0] o;
  } vec_t;
  vec_t tv[12];
  initial begin
    int loads, busy_seen, load_at;
    logic g;
    logic [W-1:0] d;
    model_reset();
    bus.GATE = 0;
    bus.I = '0;
    tv[0] = '{1, 0, 0, 0, 0, 0, 0};
    tv[1] = '{1, 0, 0, 0, 0, 0, 0};
    tv[2] = '{1, 0, 0, 0, 0, 0, 0};
    tv[3] = '{0, 1, 4'hA, 0, 0, 0, 0};
    tv[4] = '{0, 1, 4'hA, 0, 0, 0, 0};
    tv[5] = '{0, 1, 4'hA, 0, 0, 1, 0};
    tv[6] = '{0, 1, 4'hA, 0, 0, 1, 0};
    tv[7] = '{0, 1, 4'hA, 0, 0, 1, 0};
    tv[8] = '{0, 1, 4'hA, 0, 0, 1, 0};
    tv[9] = '{0, 1, 4'hA, 1, 1, 0, 4'hA};
    tv[10] = '{0, 1, 4'hA, 0, 1, 0, 4'hA};
    tv[11] = '{0, 1, 4'hA, 0, 1, 0, 4'hA};
    for (int k = 0; k < 12; k++) begin
      g = tv[k].rst ? 1'($urandom_range(0, 1)) : tv[k].gate;
      d = tv[k].rst ? W'($urandom) : tv[k].i;
      tick(tv[k].rst, g, d);
      chk("vec_LOAD", bus.LOAD, tv[k].load);
      chk("vec_GATE_LEVEL", bus.GATE_LEVEL, tv[k].lvl);
      chk("vec_BUSY", bus.BUSY, tv[k].busy);
      chk("vec_O", bus.O, tv[k].o);
    end
    loads = 0;
    busy_seen = 0;
    for (int k = 0; k < 10; k++) begin
      tick(0, k >= 2, 4'hA);
      loads += bus.LOAD;
      busy_seen += bus.BUSY;
    end
    chk("glitch_busy_seen", busy_seen > 0, 1);
    chk("glitch_no_load", loads, 0);
    chk("glitch_O", bus.O, 4'hA);
    chk("glitch_level", bus.GATE_LEVEL, 1);
    loads = 0;
    for (int k = 1; k <= 10; k++) begin
      tick(0, 0, 4'hA);
      loads += bus.LOAD;
      if (k == 6) chk("fall_level_e6", bus.GATE_LEVEL, 1);
      if (k == 7) chk("fall_level_e7", bus.GATE_LEVEL, 0);
    end
    chk("fall_no_load", loads, 0);
    loads = 0;
    for (int k = 1; k <= 12; k++) begin
      tick(0, 1, 4'h5);
      loads += bus.LOAD;
      if (k == 7) chk("rise2_load_e7", bus.LOAD, 1);
    end
    chk("rise2_one_load", loads, 1);
    chk("rise2_O", bus.O, 4'h5);
    for (int k = 0; k < 12; k++) tick(0, 0, 4'h5);
    chk("pre_reset_level", bus.GATE_LEVEL, 0);
    loads = 0;
    for (int k = 1; k <= 5; k++) begin
      tick(k == 5, 1, 4'h5);
      loads += bus.LOAD;
    end
    chk("reset_abort_no_load", loads, 0);
    chk("reset_O_cleared", bus.O, 0);
    load_at = 0;
    loads = 0;
    for (int k = 1; k <= 10; k++) begin
      tick(0, 1, 4'h5);
      loads += bus.LOAD;
      if (bus.LOAD && load_at == 0) load_at = k;
    end
    chk("reset_release_load_edge", load_at, 7);
    chk("reset_release_one_load", loads, 1);
    loads = 0;
    for (int k = 0; k < 20; k++) begin
      tick(0, 1, k[0] ? 4'h3 : 4'h5);
      loads += bus.LOAD;
    end
    chk("toggle_no_load", loads, 0);
    chk("toggle_O_held", bus.O, 4'h5);
    g = 0;
    d = '0;
    for (int k = 0; k < 600; k++) begin
      if ($urandom_range(0, 5) == 0) g = ~g;
      if ($urandom_range(0, 7) == 0) d = W'($urandom);
      tick($urandom_range(0, 79) == 0, g, d);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
